// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the execute-stage multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_op(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// Pipeline-side signals of the multiply/divide unit: decoded op, operands, status and HI/LO.
interface md_if;
  logic [2:0]  ALUMDctr;
  logic        LOHIsel;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] LOHI_out;

  modport master (
    output ALUMDctr, LOHIsel, A, B, Cancel,
    input  Start, Busy, HI, LO, LOHI_out
  );

  modport slave (
    input  ALUMDctr, LOHIsel, A, B, Cancel,
    output Start, Busy, HI, LO, LOHI_out
  );
endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing {hi, lo} and a divide-by-zero flag.
module md_compute
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        signed_div;
  logic [63:0] a_sext, b_sext;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result      = '0;
    div_by_zero = 1'b0;
    signed_div  = (op == MD_DIV);
    a_sext      = {{32{a[31]}}, a};
    b_sext      = {{32{b[31]}}, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    a_mag   = (signed_div && a[31]) ? -a : a;
    b_mag   = (signed_div && b[31]) ? -b : b;
    divisor = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (signed_div && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem     = (signed_div && a[31]) ? -r_mag : r_mag;

    case (op)
      MD_MULT:  result = a_sext * b_sext;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV, MD_DIVU: begin
        result      = {rem, quot};
        div_by_zero = (b == '0);
      end
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: fixed-latency FSM, pending result registers and architectural HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  md_state_t   state, state_next;
  md_op_t      op;
  logic [3:0]  counter;
  logic [31:0] hi, lo, pending_hi, pending_lo;
  logic        pending_dz;
  logic [63:0] result;
  logic        div_by_zero;
  logic        start, commit, mt_ok;

  assign op     = md_op_t'(md.ALUMDctr);
  assign start  = is_md_op(op) && !md.Cancel && (state == IDLE);
  assign commit = (state == BUSY) && (counter == 4'd1);
  assign mt_ok  = (state == IDLE) && !md.Cancel;

  md_compute u_compute (
    .op          (op),
    .a           (md.A),
    .b           (md.B),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = BUSY;
      BUSY:    if (commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      pending_dz <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state <= state_next;

      if (start) begin
        counter    <= ((op == MD_MULT) || (op == MD_MULTU)) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        pending_hi <= result[63:32];
        pending_lo <= result[31:0];
        pending_dz <= div_by_zero;
      end else if (state == BUSY) begin
        counter <= counter - 4'd1;
      end

      // A divide by zero still spends its latency but leaves HI/LO untouched.
      if (commit && !pending_dz) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end else if (mt_ok && (op == MD_MTLO)) begin
        lo <= md.A;
      end else if (mt_ok && (op == MD_MTHI)) begin
        hi <= md.A;
      end
    end
  end

  assign md.Start    = start;
  assign md.Busy     = (state == BUSY);
  assign md.HI       = hi;
  assign md.LO       = lo;
  assign md.LOHI_out = md.LOHIsel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected commits, a monitor checks them on Busy fall.
module tb_md_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if md();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic        prev_busy = 1'b0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference semantics computed with 64-bit integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi_n, output logic [31:0] lo_n);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi_n = model_hi;
    lo_n = model_lo;
    case (op)
      3'd1: begin p = sa * sb; hi_n = p[63:32]; lo_n = p[31:0]; end
      3'd2: begin up = ua * ub; hi_n = up[63:32]; lo_n = up[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; hi_n = r[31:0]; lo_n = q[31:0]; end
      3'd4: if (b != 0) begin up = ua / ub; lo_n = up[31:0]; up = ua % ub; hi_n = up[31:0]; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (md.Busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: Busy fell with no operation outstanding");
        end else begin
          mon_e = exp_q.pop_front();
          check("commit_hi", md.HI, mon_e.hi);
          check("commit_lo", md.LO, mon_e.lo);
          check("busy_cycles", busy_cnt, mon_e.cycles);
        end
        busy_cnt = 0;
      end
      prev_busy = md.Busy;
    end
  end

  // Issue one op from IDLE; checks Start, Busy and that HI/LO show only committed values.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    logic        exp_start;
    logic [31:0] nh, nl, old_hi, old_lo;
    @(negedge clk);
    md.ALUMDctr = op;
    md.A        = a;
    md.B        = b;
    md.Cancel   = cancel;
    exp_start   = (op >= 3'd1) && (op <= 3'd4) && !cancel;
    old_hi      = model_hi;
    old_lo      = model_lo;
    #1 check("start", md.Start, exp_start);
    if (exp_start) begin
      ref_op(op, a, b, nh, nl);
      exp_q.push_back('{hi: nh, lo: nl, cycles: (op <= 3'd2) ? MC : DC});
      model_hi = nh;
      model_lo = nl;
    end else if (!cancel && op == 3'd5) begin
      model_lo = a;
    end else if (!cancel && op == 3'd6) begin
      model_hi = a;
    end
    @(negedge clk);
    md.ALUMDctr = 3'd0;
    md.Cancel   = 1'b0;
    check("busy_after_issue", md.Busy, exp_start);
    check("hi_after_issue", md.HI, exp_start ? old_hi : model_hi);
    check("lo_after_issue", md.LO, exp_start ? old_lo : model_lo);
  endtask

  task automatic inject_busy(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic cancel);
    @(negedge clk);
    md.ALUMDctr = op;
    md.A        = a;
    md.B        = b;
    md.Cancel   = cancel;
    #1 check("start_while_busy", md.Start, 1'b0);
    @(negedge clk);
    md.ALUMDctr = 3'd0;
    md.Cancel   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (md.Busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: Busy still high after %0d cycles", n);
    end
  endtask

  task automatic check_read();
    @(negedge clk);
    md.LOHIsel = 1'b1;
    #1 check("lohi_out_hi", md.LOHI_out, model_hi);
    md.LOHIsel = 1'b0;
    #1 check("lohi_out_lo", md.LOHI_out, model_lo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_cancel;

    reset       = 1'b0;
    md.ALUMDctr = 3'd0;
    md.LOHIsel  = 1'b0;
    md.A        = '0;
    md.B        = '0;
    md.Cancel   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", md.Busy, 1'b0);
    check("reset_hi", md.HI, 32'h0);
    check("reset_lo", md.LO, 32'h0);
    #3 reset = 1'b1;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    check("mult_hi", md.HI, 32'hFFFF_FFFF);
    check("mult_lo", md.LO, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    check("multu_hi", md.HI, 32'h0000_0002);
    check("multu_lo", md.LO, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    check("div_hi", md.HI, 32'hFFFF_FFFF);
    check("div_lo", md.LO, 32'hFFFF_FFFD);
    issue(3'd4, 32'd7, 32'd2, 1'b0);
    wait_idle();
    check("divu_hi", md.HI, 32'd1);
    check("divu_lo", md.LO, 32'd3);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check("div_ovf_hi", md.HI, 32'h0);
    check("div_ovf_lo", md.LO, 32'h8000_0000);

    issue(3'd6, 32'h11, 32'd0, 1'b0);
    issue(3'd5, 32'h22, 32'd0, 1'b0);
    issue(3'd4, 32'd5, 32'd0, 1'b0);
    wait_idle();
    check("dz_hi", md.HI, 32'h11);
    check("dz_lo", md.LO, 32'h22);

    issue(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check_read();
    issue(3'd6, 32'h1234_5678, 32'd0, 1'b1);
    check("cancel_mthi", md.HI, 32'hDEAD_BEEF);

    issue(3'd1, 32'd6, 32'd7, 1'b0);
    inject_busy(3'd5, 32'hAAAA, 32'd0, 1'b0);
    inject_busy(3'd4, 32'd9, 32'd2, 1'b0);
    wait_idle();
    check("b2b_hi", md.HI, 32'd0);
    check("b2b_lo", md.LO, 32'd42);
    issue(3'd1, 32'd3, 32'd3, 1'b1);

    issue(3'd1, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", md.Busy, 1'b0);
    check("arst_hi", md.HI, 32'h0);
    check("arst_lo", md.LO, 32'h0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    #3 reset = 1'b1;
    issue(3'd1, 32'd5, 32'd5, 1'b0);
    wait_idle();
    check("post_reset_lo", md.LO, 32'd25);

    for (int i = 0; i < 60; i++) begin
      r_op     = 3'($urandom_range(0, 7));
      r_a      = $urandom;
      r_b      = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      r_cancel = ($urandom_range(0, 5) == 0);
      issue(r_op, r_a, r_b, r_cancel);
      if (r_op >= 3'd1 && r_op <= 3'd4 && !r_cancel && $urandom_range(0, 1) == 1)
        inject_busy(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_idle();
      check_read();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the decoder's ALUMDctr and LOHIsel codes plus the two forwarded E-stage operands.
- Models fixed multi-cycle latency and exposes Start/Busy so hazard logic can stall later md/mflo/mfhi instructions.
- Supplies the mflo/mfhi read value to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high after a mult/multu start; legal range 1..15.
- DIV_CYCLES, 10, cycles Busy stays high after a div/divu start; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ALUMDctr  input  3  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 reserved (treated as none).
- LOHIsel  input  1  read select: 1 = HI, 0 = LO.
- A  input  32  operand rs (dividend / multiplicand / mt source).
- B  input  32  operand rt (divisor / multiplier).
- Cancel  input  1  E-stage instruction is being flushed (interrupt/exception); suppresses start and mt writes this cycle.
- Start  output  1  combinational: op in 1..4, Cancel=0, state IDLE.
- Busy  output  1  registered: operation in flight.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.
- LOHI_out  output  32  combinational: LOHIsel ? HI : LO, committed values only.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0, pending=0, state IDLE. Reset mid-operation discards the pending result.
- States: IDLE, BUSY.
- IDLE, Start=1 at an edge:
  - Capture the full result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Go to BUSY; Busy=1 from this edge.
- BUSY: counter decrements each edge. At the edge where counter==1, commit pending to HI/LO, set Busy=0 and return to IDLE. Busy is therefore high for exactly N cycles, and the new HI/LO are visible on the first cycle Busy=0.
- mult: signed 32x32 to 64; HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder carrying the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, op 3 or 4): full latency still runs; at commit HI/LO keep their previous values.
- mtlo/mthi in IDLE with Cancel=0: write A to LO/HI at the next edge, no busy period.
- Any op code while BUSY is ignored (Start=0; mt writes dropped). Upstream stall logic must prevent this.
- Cancel=1: no start and no mt write that cycle. Cancel does not abort an operation already in BUSY.
- No bypass: LOHI_out never shows pending values.
- Stall contract for hazard logic: stall a D-stage md/mflo/mfhi instruction while (Start | Busy).

Decomposition:
- Package md_pkg holds:
  - ALUMDctr encodings MD_NONE..MD_MTHI.
  - State encoding IDLE/BUSY.
  - Default latency constants.
- One sub-module, md_compute: purely combinational; takes op, A and B; returns the 64-bit {hi,lo} result and a div_by_zero flag.
- md_unit keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset while BUSY mid-mult -> Busy=0 and HI=LO=0 immediately, asynchronously; Start re-accepted on the next cycle.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
- Divide by zero: prior HI=0x11, LO=0x22, then divu B=0 -> Busy runs 10 cycles; HI=0x11, LO=0x22 unchanged.
- mthi A=0xDEADBEEF, then LOHIsel=1 next cycle -> LOHI_out=0xDEADBEEF. The same mthi with Cancel=1 -> HI unchanged.
- Back-to-back: mult start, then mtlo and divu issued during Busy -> both ignored; HI/LO equal the mult result only. Start with Cancel=1 -> Busy stays 0.
